// File: rtl/serial_frame_rx.sv
// Start/data/stop serial frame receiver with a one-deep output register,
// sticky overrun / framing-error flags and a ready/valid consumer handshake.
module serial_frame_rx #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           serialin,
  input  logic           bit_en,
  input  logic           ready,
  input  logic           clear_err,
  output logic [WIDTH:1] q,
  output logic           valid,
  output logic           busy,
  output logic           overrun,
  output logic           frame_err
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] DATA = 2'd1;
  localparam logic [1:0] STOP = 2'd2;

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH:1]   shreg;
  logic [WIDTH:1]   shreg_next;
  logic             good_frame;
  logic             bad_frame;

  // LSB-first shifts right so the first bit settles in bit 1; MSB-first shifts left.
  assign shreg_next = MSB_FIRST ? {shreg[WIDTH-1:1], serialin}
                                : {serialin, shreg[WIDTH:2]};

  assign good_frame = bit_en && (state == STOP) && serialin;
  assign bad_frame  = bit_en && (state == STOP) && !serialin;
  assign busy       = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      shreg <= '0;
    end else if (bit_en) begin
      case (state)
        IDLE: begin
          if (!serialin) begin
            state <= DATA;
            cnt   <= '0;
          end
        end
        DATA: begin
          shreg <= shreg_next;
          cnt   <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) begin
            state <= STOP;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // A commit while the previous frame is still held and not being taken is dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q     <= '0;
      valid <= 1'b0;
    end else if (good_frame && (!valid || ready)) begin
      q     <= shreg;
      valid <= 1'b1;
    end else if (!good_frame && valid && ready) begin
      valid <= 1'b0;
    end
  end

  // Error events win over a clear on the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (good_frame && valid && !ready) begin
        overrun <= 1'b1;
      end else if (clear_err) begin
        overrun <= 1'b0;
      end
      if (bad_frame) begin
        frame_err <= 1'b1;
      end else if (clear_err) begin
        frame_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_serial_frame_rx.sv
// Bench for serial_frame_rx: an LSB-first and an MSB-first instance share the
// same serial stimulus and are checked every cycle against a frame-level model.
module tb_serial_frame_rx;

  localparam int W = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic serialin = 1'b1;
  logic bit_en = 1'b0;
  logic ready = 1'b0;
  logic clear_err = 1'b0;

  logic [W:1] q_l, q_m;
  logic valid_l, busy_l, ov_l, fe_l;
  logic valid_m, busy_m, ov_m, fe_m;

  int total = 0;
  int bad = 0;
  bit cmp_on = 1'b0;
  bit rand_mode = 1'b0;

  always #5 clk = ~clk;

  serial_frame_rx #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .reset(reset), .serialin(serialin), .bit_en(bit_en),
    .ready(ready), .clear_err(clear_err), .q(q_l), .valid(valid_l),
    .busy(busy_l), .overrun(ov_l), .frame_err(fe_l)
  );

  serial_frame_rx #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .reset(reset), .serialin(serialin), .bit_en(bit_en),
    .ready(ready), .clear_err(clear_err), .q(q_m), .valid(valid_m),
    .busy(busy_m), .overrun(ov_m), .frame_err(fe_m)
  );

  // Model: phase -1 is idle, 0..W is the number of data bits collected so far.
  int         mphase;
  logic [15:0] mbits;
  logic [W:1] mq_l, mq_m;
  logic       mvalid, mov, mfe;
  logic       mgood, mbad;

  assign mgood = bit_en && serialin && (mphase == W);
  assign mbad  = bit_en && !serialin && (mphase == W);

  function automatic logic [W:1] lsb_val(input logic [15:0] b);
    logic [W:1] v;
    for (int i = 0; i < W; i++) v[i+1] = b[i];
    return v;
  endfunction

  function automatic logic [W:1] msb_val(input logic [15:0] b);
    logic [W:1] v;
    for (int i = 0; i < W; i++) v[W-i] = b[i];
    return v;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mphase <= -1;
      mbits  <= '0;
      mq_l   <= '0;
      mq_m   <= '0;
      mvalid <= 1'b0;
      mov    <= 1'b0;
      mfe    <= 1'b0;
    end else begin
      if (bit_en) begin
        if (mphase < 0) begin
          if (!serialin) mphase <= 0;
        end else if (mphase < W) begin
          mbits[mphase] <= serialin;
          mphase <= mphase + 1;
        end else begin
          mphase <= -1;
        end
      end
      if (mgood) begin
        if (!mvalid || ready) begin
          mq_l   <= lsb_val(mbits);
          mq_m   <= msb_val(mbits);
          mvalid <= 1'b1;
        end
      end else if (mvalid && ready) begin
        mvalid <= 1'b0;
      end
      if (mgood && mvalid && !ready) mov <= 1'b1;
      else if (clear_err) mov <= 1'b0;
      if (mbad) mfe <= 1'b1;
      else if (clear_err) mfe <= 1'b0;
    end
  end

  task automatic check_output(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_on) begin
      check_output("q_lsb", 16'(q_l), 16'(mq_l));
      check_output("q_msb", 16'(q_m), 16'(mq_m));
      check_output("valid", {14'd0, valid_m, valid_l}, {14'd0, mvalid, mvalid});
      check_output("busy", {14'd0, busy_m, busy_l}, {14'd0, mphase >= 0, mphase >= 0});
      check_output("overrun", {14'd0, ov_m, ov_l}, {14'd0, mov, mov});
      check_output("frame_err", {14'd0, fe_m, fe_l}, {14'd0, mfe, mfe});
    end
  end

  // Called at a falling edge; returns at the falling edge after the sampling edge.
  task automatic apply_stimulus_bit(input logic b, input int gap);
    if (rand_mode) begin
      ready     = 1'($urandom_range(0, 1));
      clear_err = ($urandom_range(0, 7) == 0);
    end
    serialin = b;
    bit_en   = 1'b1;
    @(negedge clk);
    bit_en = 1'b0;
    for (int g = 0; g < gap; g++) begin
      serialin = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    serialin = 1'b1;
  endtask

  task automatic apply_stimulus(input logic [15:0] data, input logic stopb, input int gap,
                                input int stop_ready);
    apply_stimulus_bit(1'b0, gap);
    for (int i = 0; i < W; i++) apply_stimulus_bit(data[i], gap);
    if (stop_ready >= 0) ready = stop_ready[0];
    apply_stimulus_bit(stopb, 0);
  endtask

  task automatic pulse_clear();
    clear_err = 1'b1;
    @(negedge clk);
    clear_err = 1'b0;
  endtask

  initial begin
    #1 reset = 1'b1;
    cmp_on = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check_output("reset_q", 16'(q_l), 16'h0000);
    check_output("reset_valid", {15'd0, valid_l}, 16'd0);
    for (int i = 0; i < 3; i++) apply_stimulus_bit(1'b1, 0);
    check_output("idle_busy", {15'd0, busy_l}, 16'd0);

    ready = 1'b1;
    apply_stimulus(16'h00B9, 1'b1, 0, -1);
    check_output("basic_q", 16'(q_l), 16'h00B9);
    check_output("basic_q_msb", 16'(q_m), 16'h009D);
    check_output("basic_valid", {15'd0, valid_l}, 16'd1);
    check_output("basic_err", {14'd0, ov_l, fe_l}, 16'd0);
    @(negedge clk);
    check_output("basic_valid_drop", {15'd0, valid_l}, 16'd0);

    apply_stimulus(16'h000F, 1'b1, 0, -1);
    check_output("msbfirst_q", 16'(q_m), 16'h00F0);
    check_output("msbfirst_lsb_q", 16'(q_l), 16'h000F);
    @(negedge clk);

    ready = 1'b0;
    apply_stimulus(16'h00B9, 1'b1, 0, -1);
    apply_stimulus(16'h00F0, 1'b1, 0, -1);
    check_output("ovr_q", 16'(q_l), 16'h00B9);
    check_output("ovr_valid", {15'd0, valid_l}, 16'd1);
    check_output("ovr_flag", {15'd0, ov_l}, 16'd1);
    check_output("ovr_model", 16'(mq_l), 16'h00B9);
    pulse_clear();
    check_output("ovr_cleared", {15'd0, ov_l}, 16'd0);
    ready = 1'b1;
    @(negedge clk);

    apply_stimulus(16'h0055, 1'b0, 0, -1);
    check_output("ferr_flag", {15'd0, fe_l}, 16'd1);
    check_output("ferr_valid", {15'd0, valid_l}, 16'd0);
    check_output("ferr_q", 16'(q_l), 16'h00B9);
    check_output("ferr_busy", {15'd0, busy_l}, 16'd0);
    pulse_clear();

    ready = 1'b0;
    apply_stimulus(16'h003C, 1'b1, 0, -1);
    apply_stimulus(16'h00A5, 1'b1, 0, 1);
    ready = 1'b0;
    check_output("simul_q", 16'(q_l), 16'h00A5);
    check_output("simul_valid", {15'd0, valid_l}, 16'd1);
    check_output("simul_ovr", {15'd0, ov_l}, 16'd0);
    ready = 1'b1;
    @(negedge clk);

    for (int k = 0; k < 2; k++) begin
      int gap;
      gap = (k == 0) ? 0 : 3;
      apply_stimulus_bit(1'b0, gap);
      apply_stimulus_bit(1'b1, gap);
      apply_stimulus_bit(1'b0, gap);
      apply_stimulus_bit(1'b1, gap);
      apply_stimulus_bit(1'b0, gap);
      #3 reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check_output("rst_mid_q", 16'(q_l), 16'h0000);
      check_output("rst_mid_busy", {15'd0, busy_l}, 16'd0);
      apply_stimulus(16'h000F, 1'b1, gap, -1);
      check_output("rst_after_q", 16'(q_l), 16'h000F);
      check_output("rst_after_q_msb", 16'(q_m), 16'h00F0);
      @(negedge clk);
    end

    rand_mode = 1'b1;
    for (int n = 0; n < 150; n++) begin
      int idles;
      idles = $urandom_range(0, 2);
      for (int i = 0; i < idles; i++) apply_stimulus_bit(1'b1, 0);
      apply_stimulus(16'($urandom), ($urandom_range(0, 9) != 0),
                     $urandom_range(0, 3), -1);
    end
    rand_mode = 1'b0;
    ready = 1'b1;
    clear_err = 1'b0;
    repeat (2) @(negedge clk);
    cmp_on = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_frame_rx.md
SERIAL_FRAME_RX -- requirements
Module: serial_frame_rx

Interface
- REQ-001 SHALL have parameter WIDTH, default 8, data bits per frame (legal 2..16).
- REQ-002 SHALL have parameter MSB_FIRST, default 0; 0 = first data bit received lands in q[1], 1 = first data bit received lands in q[WIDTH].
- REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on the rising edge.
- REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
- REQ-005 SHALL have port serialin, input, 1, serial line; idles at 1.
- REQ-006 SHALL have port bit_en, input, 1, bit strobe; serialin is sampled only on edges where bit_en=1.
- REQ-007 SHALL have port ready, input, 1, consumer accepts q when ready=1 and valid=1.
- REQ-008 SHALL have port clear_err, input, 1, clears the sticky error flags.
- REQ-009 SHALL have port q, output, [WIDTH:1], last accepted frame data.
- REQ-010 SHALL have port valid, output, 1, q holds an unconsumed frame.
- REQ-011 SHALL have port busy, output, 1, high in any state other than IDLE.
- REQ-012 SHALL have port overrun, output, 1, sticky; a good frame arrived while the previous frame was unconsumed.
- REQ-013 SHALL have port frame_err, output, 1, sticky; stop bit sampled as 0.

Function
- REQ-014 Frame format SHALL be: start bit 0, then WIDTH data bits, then stop bit 1, with one bit per bit_en strobe.
- REQ-015 The FSM SHALL have exactly the states IDLE, DATA and STOP.
- REQ-016 IDLE SHALL go to DATA on a bit_en edge with serialin=0, clearing the bit counter; serialin=1 SHALL keep the FSM in IDLE.
- REQ-017 DATA SHALL shift serialin into an internal shift register on each bit_en edge and increment the counter; after the WIDTH-th data bit it SHALL go to STOP.
- REQ-018 For MSB_FIRST=0, the shift register SHALL shift right, new bit entering at the top, so the first bit ends in bit 1; for MSB_FIRST=1, it SHALL shift left, new bit entering at bit 1.
- REQ-019 STOP with serialin=1 on a bit_en edge is a good frame: q SHALL load the shift register and valid SHALL be 1 from the next cycle; the FSM SHALL then return to IDLE.
- REQ-020 STOP with serialin=0 on a bit_en edge SHALL discard the frame, leave q and valid unchanged, set frame_err, and return to IDLE.
- REQ-021 Receive latency SHALL be q/valid updated on the clock edge that samples the stop bit.
- REQ-022 valid SHALL clear on an edge with valid=1, ready=1 and no good-frame commit on that edge.
- REQ-023 If a good frame commits while valid=1 and ready=0, q SHALL NOT change, valid SHALL stay 1, and overrun SHALL set; the new frame is dropped.
- REQ-024 If a good frame commits on the same edge as a ready handshake, q SHALL load the new frame, valid SHALL stay 1, and overrun SHALL NOT set.
- REQ-025 Edges with bit_en=0 SHALL leave the FSM, counter and shift register unchanged.
- REQ-026 clear_err=1 SHALL clear overrun and frame_err on the next edge; if an error event occurs on that same edge, the flag SHALL end up set.
- REQ-027 busy SHALL be combinational from the state: 0 in IDLE and 1 in DATA and STOP.

Reset
- REQ-028 reset=1 SHALL immediately force state to IDLE and set q=0, valid=0, overrun=0, frame_err=0, counter=0 and shift register=0, independent of clk.
- REQ-029 Reset asserted mid-frame SHALL abandon the frame; no partial data SHALL reach q.
- REQ-030 After reset deasserts, the first frame SHALL be recognised only from a new start bit.

Verification
- REQ-031 Basic: WIDTH=8, MSB_FIRST=0, ready=1, send 0,1,0,0,1,1,1,0,1,1 (bit_en every cycle) -> q=8'b10111001, valid=1 for one cycle, no error flags.
- REQ-032 MSB-first: MSB_FIRST=1, send the data bits 1,1,1,1,0,0,0,0 -> q=8'b11110000.
- REQ-033 Overrun: ready=0, send 8'hB9 then 8'hF0 -> q stays 8'hB9, valid=1, overrun=1; clear_err pulse -> overrun=0.
- REQ-034 Framing error: stop bit 0 -> frame_err=1, valid and q unchanged, busy=0 on the next cycle.
- REQ-035 Simultaneous: ready pulsed on the stop-bit edge of the second frame -> q becomes the second frame, valid=1, overrun=0.
- REQ-036 Reset mid-DATA after 4 bits, then a full frame of 8'h0F -> q=8'h0F with no corruption; bit_en gaps of 3 idle cycles between bits give the same result.
